// File: rtl/calc_engine_if.sv
// Command/result bus of the iterative calculator: one command channel and one
// result channel, each a valid/ready handshake.
//
// Handshake rule for both channels: a transfer happens on the rising clock edge
// where valid && ready are both high; the sender holds valid and its payload
// stable until that edge, and ready may depend combinationally on state only.
interface calc_engine_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [1:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result;
    logic               div_by_zero;

    modport master (
        output in_valid, op_a, op_b, op, out_ready,
        input  in_ready, out_valid, result, div_by_zero
    );

    modport slave (
        input  in_valid, op_a, op_b, op, out_ready,
        output in_ready, out_valid, result, div_by_zero
    );
endinterface

// File: rtl/calc_engine.sv
// Iterative unsigned calculator: single-cycle ADD/SUB, shift-add MUL and
// restoring DIV retiring one bit per clock, with remainder and divide-by-zero.
module calc_engine #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    calc_engine_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               out_valid;
    logic [2*WIDTH-1:0] result;
    logic               dbz;

    logic [WIDTH-1:0]   src_hi;
    logic [WIDTH-1:0]   src_lo;
    logic [WIDTH-1:0]   src_b;
    logic               step_mul;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   next_hi;
    logic [WIDTH-1:0]   next_lo;
    logic [2*WIDTH-1:0] add_sub;

    assign bus.in_ready    = (state == ST_IDLE);
    assign bus.out_valid   = out_valid;
    assign bus.result      = result;
    assign bus.div_by_zero = dbz;
    assign dbg_state       = state;

    // The first iteration runs on the accepting edge straight from the ports,
    // so W iterations finish W-1 edges later and out_valid is seen after W cycles.
    always_comb begin
        src_hi   = hi;
        src_lo   = lo;
        src_b    = b_reg;
        step_mul = (op_reg == OP_MUL);
        if (state == ST_IDLE) begin
            src_hi   = '0;
            src_lo   = bus.op_a;
            src_b    = bus.op_b;
            step_mul = (bus.op == OP_MUL);
        end

        // {hi,lo} is the product register for MUL and {remainder,quotient} for DIV.
        mul_sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
        div_shift = {src_hi, src_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, src_b};

        if (step_mul) begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], src_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            next_hi = div_diff[WIDTH-1:0];
            next_lo = {src_lo[WIDTH-2:0], 1'b1};
        end else begin
            next_hi = div_shift[WIDTH-1:0];
            next_lo = {src_lo[WIDTH-2:0], 1'b0};
        end

        add_sub = '0;
        if (bus.op == OP_SUB) begin
            add_sub[WIDTH:0] = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        end else begin
            add_sub[WIDTH:0] = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            b_reg     <= '0;
            op_reg    <= OP_ADD;
            out_valid <= 1'b0;
            result    <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        hi     <= next_hi;
                        lo     <= next_lo;
                        b_reg  <= bus.op_b;
                        op_reg <= bus.op;
                        cnt    <= CW'(WIDTH);
                        dbz    <= 1'b0;
                        case (bus.op)
                            OP_ADD, OP_SUB: begin
                                result    <= add_sub;
                                out_valid <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_MUL: state <= ST_MUL;
                            OP_DIV: begin
                                if (bus.op_b == '0) begin
                                    result    <= '0;
                                    dbz       <= 1'b1;
                                    out_valid <= 1'b1;
                                    state     <= ST_DONE;
                                end else begin
                                    state <= ST_DIV;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                ST_MUL, ST_DIV: begin
                    hi  <= next_hi;
                    lo  <= next_lo;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(2)) begin
                        result    <= {next_hi, next_lo};
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
